// File: rtl/cpu_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_arbiter_if
//  Description : Bundle of the three sram-like buses around the CPU memory
//                arbiter: instruction-fetch port, data load/store port and
//                the shared memory bus.
//                  slave  - the arbiter's view (CPU requests and memory
//                           responses in; grants, CPU responses and the
//                           merged bus request out)
//                  master - the environment's view (CPU + memory side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_mem_arbiter_if;
    // instruction-fetch port
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    // data load/store port
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    // shared memory bus
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic [31:0] mem_rdata;
    logic        mem_data_ok;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_rdata, inst_data_ok,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_rdata, data_data_ok,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_rdata, mem_data_ok
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_rdata, inst_data_ok,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_rdata, data_data_ok,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_rdata, mem_data_ok
    );
endinterface
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mem_arbiter
//  Description : Fixed-priority arbiter merging the CPU instruction-fetch and
//                data load/store ports onto one shared memory bus, one
//                transaction in flight at a time. Responses are routed back
//                to the port that owns the in-flight transaction.
//  Ports       : clk    - clock
//                reset  - synchronous active-high reset
//                bus    - cpu_mem_arbiter_if.slave (fetch, data, memory bus)
//  Parameters  : DATA_FIRST - 1: data port wins simultaneous requests,
//                             0: fetch port wins
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    cpu_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_owner_data;   // 1: in-flight transaction belongs to the data port
    logic        r_wr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_mem_req;
    logic        r_inst_data_ok;
    logic        r_data_data_ok;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;

    logic        w_idle;
    logic        w_inst_grant;
    logic        w_data_grant;

    // Grants are combinational so the winner sees addr_ok in its request cycle.
    assign w_idle       = (r_state == S_IDLE) && !reset;
    assign w_data_grant = w_idle && bus.data_req && (DATA_FIRST || !bus.inst_req);
    assign w_inst_grant = w_idle && bus.inst_req && (!DATA_FIRST || !bus.data_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_owner_data   <= 1'b0;
            r_wr           <= 1'b0;
            r_wstrb        <= 4'd0;
            r_addr         <= 32'd0;
            r_wdata        <= 32'd0;
            r_mem_req      <= 1'b0;
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
            r_inst_rdata   <= 32'd0;
            r_data_rdata   <= 32'd0;
        end else begin
            // Response pulses last exactly one cycle.
            r_inst_data_ok <= 1'b0;
            r_data_data_ok <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_data_grant) begin
                        r_owner_data <= 1'b1;
                        r_wr         <= bus.data_wr;
                        r_wstrb      <= bus.data_wstrb;
                        r_addr       <= bus.data_addr;
                        r_wdata      <= bus.data_wdata;
                        r_mem_req    <= 1'b1;
                        r_state      <= S_ISSUE;
                    end else if (w_inst_grant) begin
                        // Fetches are always reads.
                        r_owner_data <= 1'b0;
                        r_wr         <= 1'b0;
                        r_wstrb      <= 4'd0;
                        r_addr       <= bus.inst_addr;
                        r_wdata      <= 32'd0;
                        r_mem_req    <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A data_ok arriving alongside addr_ok is not consumed here;
                    // the bus must return it strictly later.
                    if (bus.mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_data_ok) begin
                        if (r_owner_data) begin
                            // A store's write-ack carries no load data.
                            if (!r_wr) begin
                                r_data_rdata <= bus.mem_rdata;
                            end
                            r_data_data_ok <= 1'b1;
                        end else begin
                            r_inst_rdata   <= bus.mem_rdata;
                            r_inst_data_ok <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.inst_addr_ok = w_inst_grant;
    assign bus.data_addr_ok = w_data_grant;
    assign bus.inst_rdata   = r_inst_rdata;
    assign bus.inst_data_ok = r_inst_data_ok;
    assign bus.data_rdata   = r_data_rdata;
    assign bus.data_data_ok = r_data_data_ok;

    // Bus fields come only from the latched request and read as zero when no
    // request is presented, so they cannot change while a slave stalls.
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_wr    = r_mem_req & r_wr;
    assign bus.mem_wstrb = {4{r_mem_req}} & r_wstrb;
    assign bus.mem_addr  = {32{r_mem_req}} & r_addr;
    assign bus.mem_wdata = {32{r_mem_req}} & r_wdata;

endmodule
`default_nettype wire

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Sits directly downstream of the CPU top.
- Accepts the instruction-fetch port and the data load/store port, each using an sram-like req/addr_ok/data_ok handshake, and merges them onto one shared memory bus.
- Allows one outstanding transaction at a time.
- Arbitration is fixed priority; each response is routed back to the port that issued the request.

Parameters:
DATA_FIRST, 1, 1 = data port wins simultaneous requests; 0 = inst port wins

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req  in  1  fetch request
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_rdata  out  32  fetch data, valid with inst_data_ok
inst_data_ok  out  1  fetch data return pulse
data_req  in  1  load/store request
data_wr  in  1  1 = store, 0 = load
data_wstrb  in  4  byte write strobes (store only)
data_addr  in  32  load/store address
data_wdata  in  32  store data
data_addr_ok  out  1  data request accepted this cycle
data_rdata  out  32  load data, valid with data_data_ok
data_data_ok  out  1  data return pulse (pulsed for stores too)
mem_req  out  1  bus request
mem_wr  out  1  bus write
mem_wstrb  out  4  bus byte strobes
mem_addr  out  32  bus address
mem_wdata  out  32  bus write data
mem_addr_ok  in  1  bus accepted request
mem_rdata  in  32  bus read data
mem_data_ok  in  1  bus data/write-ack pulse

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset: state=IDLE; all *_addr_ok, *_data_ok and mem_req are 0; mem_wr=0; mem_wstrb=0; mem_addr, mem_wdata, inst_rdata and data_rdata are 0.
- IDLE, grant:
  - If the winning port's req=1, its *_addr_ok=1 combinationally in that same cycle.
  - The request is latched: addr, wr, wstrb, wdata, and an owner bit.
  - Next state is ISSUE.
  - The losing port sees addr_ok=0 and must hold its req.
  - An inst request latches wr=0 and wstrb=0.
- IDLE, no request: stay in IDLE with all outputs 0.
- ISSUE:
  - mem_req=1, driven from the latched registers only, so it is stable while waiting.
  - mem_addr_ok=1 moves to WAIT at the next edge; otherwise stay in ISSUE indefinitely.
  - No new *_addr_ok is given while busy.
- WAIT:
  - mem_req=0.
  - On mem_data_ok=1, latch mem_rdata into the owner's rdata register and go to RESP.
  - mem_data_ok in any other state is ignored.
- RESP:
  - The owner's *_data_ok=1 for exactly one cycle; its rdata register is held until the next response to that port.
  - For a store, data_rdata is left unchanged.
  - Next state is IDLE.
  - The non-owner's data_ok stays 0.
- Throughput and latency:
  - Minimum latency from addr_ok to data_ok is 3 cycles: accept at T; mem_req at T+1 with mem_addr_ok same cycle; mem_data_ok at T+2; data_ok at T+3.
  - At most one transaction in flight, so responses are in order per port.
  - A new grant is possible in the cycle after RESP.
- Simultaneous events:
  - inst_req and data_req together in IDLE: the DATA_FIRST port is granted.
  - mem_addr_ok and mem_data_ok together in ISSUE: only addr_ok is consumed (the bus is required to return data_ok strictly later).
- Reset mid-operation: returns to IDLE immediately, the in-flight transaction is dropped with no data_ok pulse, and the owner bit clears.
- Starvation: the lower-priority port can starve under continuous higher-priority requests. This is accepted and is not the arbiter's concern.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0xBFC00000; bus addr_ok after 2 cycles, data_ok 1 later with rdata=0x3C080001 -> inst_addr_ok pulses at T0; mem_addr=0xBFC00000 and mem_wr=0; inst_data_ok=1 with inst_rdata=0x3C080001 one cycle after mem_data_ok; data_data_ok stays 0.
- Collision: inst_req and data_req both asserted in one cycle, DATA_FIRST=1, load addr 0x80001000 -> data granted first. After its RESP the inst request is granted; two mem_req bursts in order data then inst; each data_ok goes to the correct port.
- Store: data_wr=1, wstrb=4'b0011, addr=0x80002004, wdata=0xDEADBEEF -> mem_wr=1, mem_wstrb=0011 and mem_wdata=0xDEADBEEF held for the whole of ISSUE; data_data_ok pulses once; data_rdata unchanged.
- Backpressure: mem_addr_ok held 0 for 5 cycles -> mem_req and all mem_* fields stable for 5 cycles; a new inst_req during the stall gets no addr_ok.
- Reset in WAIT: assert reset for 1 cycle before mem_data_ok -> no data_ok; a later stray mem_data_ok is ignored; the next request is served normally.
- Back-to-back: 4 sequential fetches at +4 addresses with zero-latency bus -> grant every 4th cycle, rdata in order.
